// File: rtl/fft_bfly_stage1.sv
// -----------------------------------------------------------------------------
// fft_bfly_stage1
//   First radix-2 DIT butterfly stage. Consumes the bit-reversed complex stream
//   from the reorder buffer, pairs consecutive samples A, B (twiddle = 1) and
//   emits (A+B)/2 followed by (A-B)/2. Sustains 1 sample/cycle in and out.
//
//   Build option: define FFT_BFLY_STAGE1_ROUND_EN for round-half-up with
//   saturation. Otherwise the result is a floor (truncating) shift.
//
// Ports
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   valid_i  input sample valid
//   data_i   input complex sample {im[DW-1:DW/2], re[DW/2-1:0]}
//   ready_o  block accepts data_i this cycle
//   valid_o  output sample valid
//   data_o   output complex sample {im, re}
//   last_o   final output sample of a frame
//   ready_i  downstream accepts data_o
// -----------------------------------------------------------------------------
module fft_bfly_stage1 #(
  parameter int unsigned K  = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  input  logic          ready_i
);

  localparam int unsigned H = DW / 2;
  // N/2-1 is all ones in the K-1 bit pair counter.
  localparam logic [K-2:0] LAST_PAIR = '1;

  typedef enum logic [1:0] {S_A, S_B, S_SUM, S_DIFF} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic          a_held_q, a_held_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [DW-1:0] diff_q, diff_d;
  logic [K-2:0]  pair_cnt_q, pair_cnt_d;

  logic          in_xfer, out_xfer;
  logic [DW-1:0] sum_new, diff_new;

  // One component of the butterfly: (a +/- b) / 2 in H+1 bits, back to H bits.
  function automatic logic [H-1:0] half_bfly(input logic [H-1:0] a,
                                             input logic [H-1:0] b,
                                             input logic         sub);
    logic [H:0] s;
`ifdef FFT_BFLY_STAGE1_ROUND_EN
    logic [H+1:0] t;
`endif
    if (sub) s = {a[H-1], a} - {b[H-1], b};
    else     s = {a[H-1], a} + {b[H-1], b};
`ifdef FFT_BFLY_STAGE1_ROUND_EN
    t = {s[H], s} + {{(H+1){1'b0}}, 1'b1};
    // The rounded result t[H+1:1] overflows H bits only when its top two bits differ.
    if (t[H+1] != t[H]) half_bfly = t[H+1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
    else                half_bfly = t[H:1];
`else
    half_bfly = s[H:1];
`endif
  endfunction

  assign sum_new  = {half_bfly(a_q[DW-1:H], data_i[DW-1:H], 1'b0),
                     half_bfly(a_q[H-1:0],  data_i[H-1:0],  1'b0)};
  assign diff_new = {half_bfly(a_q[DW-1:H], data_i[DW-1:H], 1'b1),
                     half_bfly(a_q[H-1:0],  data_i[H-1:0],  1'b1)};

  // Handshake outputs, decoded from the state alone plus ready_i.
  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    last_o  = 1'b0;
    ready_o = 1'b1;
    unique case (state_q)
      S_SUM: begin
        valid_o = 1'b1;
        data_o  = sum_q;
        ready_o = ready_i & ~a_held_q;
      end
      S_DIFF: begin
        valid_o = 1'b1;
        data_o  = diff_q;
        last_o  = (pair_cnt_q == LAST_PAIR);
        ready_o = ready_i;
      end
      default: ;
    endcase
  end

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    a_held_d   = a_held_q;
    sum_d      = sum_q;
    diff_d     = diff_q;
    pair_cnt_d = pair_cnt_q;
    unique case (state_q)
      S_A: begin
        if (in_xfer) begin
          a_d     = data_i;
          state_d = S_B;
        end
      end
      S_B: begin
        if (in_xfer) begin
          sum_d   = sum_new;
          diff_d  = diff_new;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        if (out_xfer) state_d = S_DIFF;
        // Next A arrives while the sum leaves; park it for the diff cycle.
        if (in_xfer) begin
          a_d      = data_i;
          a_held_d = 1'b1;
        end
      end
      S_DIFF: begin
        if (out_xfer) begin
          pair_cnt_d = (pair_cnt_q == LAST_PAIR) ? '0 : pair_cnt_q + 1'b1;
          if (a_held_q) begin
            a_held_d = 1'b0;
            if (in_xfer) begin
              sum_d   = sum_new;
              diff_d  = diff_new;
              state_d = S_SUM;
            end else begin
              state_d = S_B;
            end
          end else if (in_xfer) begin
            a_d     = data_i;
            state_d = S_B;
          end else begin
            state_d = S_A;
          end
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_A;
      a_q        <= '0;
      a_held_q   <= 1'b0;
      sum_q      <= '0;
      diff_q     <= '0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      a_held_q   <= a_held_d;
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_stage1.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_stage1
//   Scoreboard bench for fft_bfly_stage1. The driver pushes expected outputs
//   when a pair completes; an independent monitor pops and compares on every
//   output transfer.
// -----------------------------------------------------------------------------
module tb_fft_bfly_stage1;

  localparam int unsigned K  = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned H  = DW / 2;
  localparam int unsigned N  = 1 << K;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i  = '0;
  logic          ready_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;

  fft_bfly_stage1 #(.K(K), .DW(DW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            last_cycs[$];
  int            acc_cyc  = 0;
  bit            acc_valid_o = 1'b0;
  bit            use_model  = 1'b1;
  bit            rand_ready = 1'b0;
  bit            have_a     = 1'b0;
  logic [DW-1:0] a_smp      = '0;
  int            pair_idx   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic, floor via arithmetic shift of a signed int.
  function automatic logic [H-1:0] ref_half(input logic [H-1:0] x, input logic [H-1:0] y, input bit sub);
    int a, b, s, r;
    a = int'($signed(x));
    b = int'($signed(y));
    s = sub ? a - b : a + b;
`ifdef FFT_BFLY_STAGE1_ROUND_EN
    r = (s + 1) >>> 1;
    if (r > (1 << (H-1)) - 1) r = (1 << (H-1)) - 1;
`else
    r = s >>> 1;
`endif
    return r[H-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_cplx(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sub);
    return {ref_half(a[DW-1:H], b[DW-1:H], sub), ref_half(a[H-1:0], b[H-1:0], sub)};
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    if (!have_a) begin
      a_smp  = d;
      have_a = 1'b1;
    end else begin
      if (use_model) begin
        push_exp(ref_cplx(a_smp, d, 1'b0), 1'b0);
        push_exp(ref_cplx(a_smp, d, 1'b1), (pair_idx % (N/2)) == (N/2 - 1));
      end
      pair_idx++;
      have_a = 1'b0;
    end
  endtask

  // Drive one sample; returns 1ns after the accepting clock edge.
  task automatic send(input logic [DW-1:0] d);
    int w;
    w = 0;
    valid_i = 1'b1;
    data_i  = d;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      w++;
      if (w > 2000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: ready_o stuck at %b for %0d cycles, required 1", ready_o, w);
        break;
      end
    end
    acc_cyc     = cyc;
    acc_valid_o = valid_o;
    model_accept(d);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("rst_valid_o", {31'b0, valid_o}, 32'd0);
    check("rst_ready_o", {31'b0, ready_o}, 32'd1);
    check("rst_last_o",  {31'b0, last_o},  32'd0);
    check("rst_data_o",  data_o, 32'd0);
    sb.delete();
    have_a   = 1'b0;
    pair_idx = 0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 5000) begin
      @(posedge clk_i);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d outputs outstanding, required 0", sb.size());
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Random downstream backpressure.
  initial forever begin
    @(posedge clk_i);
    #1;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  // Monitor: compare every output transfer against the scoreboard.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    exp_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall && valid_o) begin
        check("hold_data", data_o, prev_data);
        check("hold_last", {31'b0, last_o}, {31'b0, prev_last});
      end
      if (valid_o && !ready_i) check("stall_ready_o", {31'b0, ready_o}, 32'd0);
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h last %b, required no output", data_o, last_o);
        end else begin
          e = sb.pop_front();
          check("data_o", data_o, e.data);
          check("last_o", {31'b0, last_o}, {31'b0, e.last});
        end
        if (last_o) last_cycs.push_back(cyc);
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_last  = last_o;
    end
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    #3;
    do_reset();

    // Basic pair and first-output latency.
    ready_i   = 1'b1;
    use_model = 1'b0;
    push_exp({16'hffec, 16'd60}, 1'b0);   // im -20, re 60
    push_exp({16'hffe2, 16'd40}, 1'b0);   // im -30, re 40
    send({16'hffce, 16'd100});            // im -50, re 100
    send({16'd10, 16'd20});
    check("lat_idle_at_b", {31'b0, acc_valid_o}, 32'd0);
    check("lat_sum_valid", {31'b0, valid_o}, 32'd1);
    check("lat_sum_data", data_o, {16'hffec, 16'd60});
    drain();

    // Extremes and rounding.
`ifdef FFT_BFLY_STAGE1_ROUND_EN
    push_exp({16'h0, 16'h0000}, 1'b0);
    push_exp({16'h0, 16'h7fff}, 1'b0);
    push_exp({16'h0, 16'd2}, 1'b0);
    push_exp({16'h0, 16'd2}, 1'b0);
`else
    push_exp({16'h0, 16'hffff}, 1'b0);
    push_exp({16'h0, 16'h7fff}, 1'b0);
    push_exp({16'h0, 16'd1}, 1'b0);
    push_exp({16'h0, 16'd1}, 1'b0);
`endif
    send({16'h0, 16'h7fff});
    send({16'h0, 16'h8000});
    send({16'h0, 16'd3});
    send({16'h0, 16'd0});
    drain();

    // Two continuous frames at full rate.
    do_reset();
    use_model = 1'b1;
    ready_i   = 1'b1;
    last_cycs.delete();
    send($urandom);
    first = acc_cyc;
    for (int i = 1; i < 2 * N; i++) send($urandom);
    drain();
    check("stream_last_count", 32'(last_cycs.size()), 32'd2);
    if (last_cycs.size() == 2) begin
      check("stream_frame0_cycles", 32'(last_cycs[0] - first), 32'd1025);
      check("stream_frame1_cycles", 32'(last_cycs[1] - first), 32'd2049);
    end

    // Random backpressure over three frames.
    do_reset();
    last_cycs.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) send($urandom);
    drain();
    @(posedge clk_i);
    #2;
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    drain();
    check("bp_last_count", 32'(last_cycs.size()), 32'd3);

    // Held A with input gap during the diff cycle.
    do_reset();
    use_model = 1'b0;
    push_exp({16'h0, 16'd8}, 1'b0);
    push_exp({16'h0, 16'd2}, 1'b0);
    push_exp({16'h0, 16'hfffe}, 1'b0);
    push_exp({16'h0, 16'hfffb}, 1'b0);
    send({16'h0, 16'd10});
    send({16'h0, 16'd6});
    send({16'h0, 16'hfff9});              // -7, captured during the sum cycle
    repeat (2) @(posedge clk_i);
    #1;
    check("gap_valid_o", {31'b0, valid_o}, 32'd0);
    check("gap_ready_o", {31'b0, ready_o}, 32'd1);
    send({16'h0, 16'd3});
    drain();
    use_model = 1'b1;

    // Reset in the middle of a pair, then one full frame.
    do_reset();
    for (int i = 0; i < 5; i++) send($urandom);
    do_reset();
    last_cycs.delete();
    for (int i = 0; i < N; i++) send($urandom);
    drain();
    check("rst_frame_last_count", 32'(last_cycs.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
